// File: rtl/proc_pkg.sv
// Shared processor constants for the multicycle datapath.
// Widths, opcodes and the LM/SM sequencer states.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int IDX_W  = $clog2(NREGS);

  localparam logic [3:0] OP_LM = 4'd6;
  localparam logic [3:0] OP_SM = 4'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder.
// Reports the index of bit 0-most set bit plus a valid flag.
module lsb_priority_enc #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  in,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // scan high to low so the lowest set bit is assigned last
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx   = i[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Register-list walker for LM/SM multi-register transfers.
// One memory transfer per set list bit, lowest register first.
module lmsm_sequencer #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int NREGS  = proc_pkg::NREGS
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREGS-1:0]  reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              mem_ack,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [2:0]        reg_idx,
  output logic              rf_wen,
  output logic              done,
  output logic [3:0]        xfer_count
);

  import proc_pkg::*;

  localparam int IW = $clog2(NREGS);

  logic [1:0]        rst_q;
  logic              rst_n;
  logic [1:0]        state;
  logic [NREGS-1:0]  mask;
  logic [NREGS-1:0]  mask_clr;
  logic [NREGS-1:0]  enc_in;
  logic [DATA_W-1:0] ptr;
  logic [3:0]        count;
  logic              we;
  logic [IW-1:0]     cur_idx;
  logic [IW-1:0]     enc_idx;
  logic              enc_valid;

  // reset asserts at once, releases two clocks after proc_rst rises
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) rst_q <= 2'b00;
    else           rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  assign mask_clr =
    mask & ~({{(NREGS-1){1'b0}}, 1'b1} << cur_idx);

  // one encoder: new list in IDLE, remaining list otherwise
  assign enc_in = (state == S_IDLE) ? reg_list : mask_clr;

  lsb_priority_enc #(
    .W  (NREGS),
    .IW (IW)
  ) u_enc (
    .in    (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // walker state: latch on start, advance on each ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mask    <= '0;
      ptr     <= '0;
      count   <= '0;
      we      <= 1'b0;
      cur_idx <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mask    <= reg_list;
            ptr     <= base_addr;
            we      <= is_store;
            count   <= '0;
            cur_idx <= enc_idx;
            state   <= enc_valid ? S_XFER : S_DONE;
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            mask  <= mask_clr;
            ptr   <= ptr + 1'b1;
            count <= count + 4'd1;
            if (enc_valid) cur_idx <= enc_idx;
            else           state   <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign mem_req    = (state == S_XFER);
  assign mem_we     = mem_req & we;
  assign mem_addr   = ptr;
  assign reg_idx    = 3'(cur_idx);
  assign rf_wen     = mem_req & mem_ack & ~mem_we;
  assign done       = (state == S_DONE);
  assign xfer_count = count;

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Register-list walker for the Load-Multiple (LM, opcode 6) and Store-Multiple (SM, opcode 7) instructions; sits directly downstream of the multicycle controller.
- On a start pulse it latches the 8-bit register list from IR[7:0] and a base address. It then issues one memory transfer per set bit, lowest register first, at consecutive word addresses.
- For LM it drives register-file write enable and index. For SM it drives memory write and the register-file read index.
- It replaces the controller's fixed 0..7 counter loop, so clear bits in the list cost no cycles.

Parameters:
- DATA_W, 16, address/data width
- NREGS, 8, register-list width and register count (index width = log2(NREGS))

Ports:
- clk  in  1  clock; all state updates on the rising edge
- proc_rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- is_store  in  1  0 = LM, 1 = SM; latched with start
- reg_list  in  NREGS  register list (IR[7:0]); latched with start
- base_addr  in  DATA_W  first transfer address; latched with start
- mem_ack  in  1  memory completes the current transfer when high with mem_req
- busy  out  1  high in every state except IDLE
- mem_req  out  1  transfer request, held until acknowledged
- mem_we  out  1  = latched is_store while mem_req is high, else 0
- mem_addr  out  DATA_W  address of the current transfer
- reg_idx  out  3  register index of the current transfer
- rf_wen  out  1  LM write strobe: mem_req & mem_ack & ~mem_we (combinational)
- done  out  1  one-cycle completion pulse
- xfer_count  out  4  number of completed transfers; holds its value after done until the next accepted start

Behaviour:
- Reset (async assert, sync deassert internally): state = IDLE, mask = 0, ptr = 0, count = 0. All outputs are 0 (busy, mem_req, mem_we, mem_addr, reg_idx, rf_wen, done, xfer_count).
- States: IDLE, XFER, DONE.
- IDLE: on start=1, latch mask = reg_list, ptr = base_addr, we = is_store, and clear count to 0.
  - If reg_list == 0, go to DONE.
  - Otherwise go to XFER with reg_idx = index of the lowest set bit of reg_list.
- XFER: mem_req = 1, mem_addr = ptr, reg_idx is stable.
  - Without mem_ack: hold all outputs and stay in XFER.
  - With mem_ack: clear mask[reg_idx], ptr <= ptr + 1 (mod 2^DATA_W, wraps 0xFFFF -> 0x0000), count <= count + 1.
  - If the remaining mask is nonzero, stay in XFER with reg_idx = lowest remaining set bit; mem_req stays high with no bubble.
  - If the remaining mask is zero, go to DONE.
- DONE: done = 1 for exactly one cycle, mem_req = 0, then go to IDLE.
- Latency: with start in cycle 0, the first mem_req is visible in cycle 1. With mem_ack tied high, N set bits give done in cycle N+1. An empty list gives done in cycle 1.
- start while busy is ignored, with no effect on latched values.
- start in the same cycle as done is ignored. A new start is accepted only from IDLE, i.e. one cycle after done.
- rf_wen is high only in cycles where an LM transfer is acknowledged. reg_idx in that cycle is the destination register.
- Reset asserted mid-transfer forces IDLE immediately. No done pulse is produced, and any partially loaded registers remain written.
- mem_ack outside XFER is ignored.
- xfer_count width covers 0..8.

Decomposition:
- Shared package (proc_pkg): DATA_W, NREGS, opcode constants OP_LM = 4'd6 and OP_SM = 4'd7, and the state enum for this block.
- One natural sub-module: lsb_priority_enc (NREGS-bit input, outputs index of lowest set bit plus a valid flag). It is used both at start and after each ack.

Test Plan:
- LM, reg_list=8'b1010_0101, base=0x0040, mem_ack tied 1 -> reg_idx 0,2,5,7 at addresses 0x0040..0x0043 in cycles 1-4; rf_wen high in cycles 1-4; done in cycle 5; xfer_count=4.
- SM, reg_list=8'hFF, base=0xFFFE, ack every other cycle -> mem_we=1 throughout; addresses 0xFFFE, 0xFFFF, 0x0000 … 0x0005; rf_wen never high; xfer_count=8.
- reg_list=0, start -> done in cycle 1; mem_req never asserted; xfer_count=0.
- start pulsed again while busy, with different reg_list and base -> ignored; original sequence completes unchanged.
- mem_ack held low for 5 cycles on the first transfer -> mem_req, mem_addr and reg_idx stable for those 5 cycles; sequence proceeds after ack.
- proc_rst driven low during the 2nd transfer of 8'h0F -> all outputs 0 immediately with no done pulse; a following start of 8'h01 behaves as a fresh operation.
